// File: rtl/msk_drain_pkg.sv
// Shared constants for the masked ciphertext drain: word count, counter width, state encoding.
package msk_drain_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_t;

    function automatic int drain_num_words(input int num_shares, input int word_w);
        return (128 / word_w) * num_shares;
    endfunction

    function automatic int drain_cnt_width(input int num_words);
        return (num_words <= 2) ? 1 : $clog2(num_words);
    endfunction

    localparam int DRAIN_D_DEF     = 2;
    localparam int DRAIN_W_DEF     = 32;
    localparam int DRAIN_N_DEF     = drain_num_words(DRAIN_D_DEF, DRAIN_W_DEF);
    localparam int DRAIN_CNT_W_DEF = drain_cnt_width(DRAIN_N_DEF);

endpackage

// File: rtl/msk_share_word_sel.sv
// Selects output word k from the bit-compact share buffer (share-major, low word first).
// Latency: combinational.
// Backpressure: none; pure function of buffer and word index.
module msk_share_word_sel
    import msk_drain_pkg::*;
#(
    parameter int D     = 2,
    parameter int W     = 32,
    parameter int CNT_W = drain_cnt_width(drain_num_words(D, W))
) (
    input  logic [128*D-1:0] cap_dat,
    input  logic [CNT_W-1:0] word_idx,
    output logic [W-1:0]     word_dat
);

    localparam int WPS = 128 / W;
    localparam int N   = drain_num_words(D, W);

    // Every index below is constant, so this elaborates to a plain N:1 mux per bit.
    always_comb begin
        word_dat = '0;
        for (int k = 0; k < N; k++) begin
            if (word_idx == CNT_W'(k)) begin
                for (int j = 0; j < W; j++) begin
                    word_dat[j] = cap_dat[((k % WPS) * W + j) * D + (k / WPS)];
                end
            end
        end
    end

endmodule

// File: rtl/msk_ciphertext_drain.sv
// Captures one masked ciphertext from the core and streams its shares out as W-bit words.
// Latency: first word valid the cycle after capture; one bubble cycle between ciphertexts.
// Backpressure: m_ready stalls the stream with data held; out_ready stays low until the buffer is drained.
module msk_ciphertext_drain
    import msk_drain_pkg::*;
#(
    parameter int d = 2,
    parameter int W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cipher_valid,
    output logic             out_ready,
    input  logic [128*d-1:0] sh_ciphertext,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W-1:0]     m_data,
    output logic             m_last,
    output logic             busy
);

    localparam int N     = drain_num_words(d, W);
    localparam int CNT_W = drain_cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    drain_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [128*d-1:0] cap_dat;
    logic [W-1:0]     sel_dat;

    assign cnt_nxt = cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            out_ready <= 1'b0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
            cap_dat   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cipher_valid && out_ready) begin
                        cap_dat   <= sh_ciphertext;
                        out_ready <= 1'b0;
                        state     <= STREAM;
                        m_valid   <= 1'b1;
                        m_last    <= (N == 1);
                        busy      <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        out_ready <= 1'b1;
                    end
                end
                STREAM: begin
                    if (m_ready) begin
                        if (cnt == LAST_IDX) begin
                            // Zeroize as soon as the last share word has left.
                            cap_dat   <= '0;
                            state     <= IDLE;
                            m_valid   <= 1'b0;
                            m_last    <= 1'b0;
                            busy      <= 1'b0;
                            out_ready <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            cnt    <= cnt_nxt;
                            m_last <= (cnt_nxt == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    msk_share_word_sel #(
        .D     (d),
        .W     (W),
        .CNT_W (CNT_W)
    ) u_word_sel (
        .cap_dat  (cap_dat),
        .word_idx (cnt),
        .word_dat (sel_dat)
    );

    assign m_data = m_valid ? sel_dat : '0;

endmodule

// File: doc/msk_ciphertext_drain.md
Name: msk_ciphertext_drain

Overview:
- Consumer end of the masked AES core's output handshake.
- Drives out_ready and captures the bit-compact masked ciphertext when cipher_valid and out_ready are both high.
- Streams the captured shares out as W-bit words over a valid/ready/last interface toward the host/UART bridge. Never recombines shares.
- Zeroizes its buffer once streaming completes, so sensitive data does not persist.

Parameters:
- d, 2, number of shares (matches the core's d).
- W, 32, output word width; 128 % W must be 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-low (asserted when 0).
- cipher_valid  input  1  core ciphertext valid.
- out_ready  output  1  drain can accept a ciphertext.
- sh_ciphertext  input  128*d  masked ciphertext, bit-compact: share s of bit b at index b*d+s.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accepts word.
- m_data  output  W  output word.
- m_last  output  1  high on the final word of a ciphertext.
- busy  output  1  high while holding or streaming data.

Behaviour:
- N = (128/W)*d words per ciphertext; word counter width clog2(N), minimum 1.
- States: IDLE, STREAM.
- Reset (rst==0 at a clock edge):
  - state=IDLE, out_ready=0, m_valid=0, m_last=0, busy=0, counter=0, buffer=0.
  - m_data=0 whenever m_valid=0.
- out_ready is registered:
  - Goes to 1 the first cycle after reset is released.
  - Stays 1 in IDLE until a capture.
- IDLE:
  - On cipher_valid & out_ready, capture sh_ciphertext into the buffer.
  - Next cycle: out_ready=0, state=STREAM, m_valid=1, counter=0, busy=1.
  - cipher_valid while out_ready=0 is ignored; the core holds its data.
- STREAM, word k (0..N-1):
  - Share s = k / (128/W), word index w = k % (128/W).
  - m_data[j] = buffer[(w*W + j)*d + s] for j in 0..W-1. Shares are emitted share-major, low word first.
  - m_last = (k == N-1).
  - On m_valid & m_ready: counter increments.
  - m_valid must not drop, and m_data/m_last must not change, while m_ready=0.
- After the last word is accepted:
  - Next cycle: buffer cleared to 0, state=IDLE, m_valid=0, m_last=0, busy=0, out_ready=1.
  - This gives one bubble cycle minimum between ciphertexts. No capture is allowed in the same cycle as the last accept.
- Reset mid-STREAM:
  - Aborts streaming and clears the buffer and counter. The partial ciphertext is lost.
  - out_ready returns to 1 one cycle after reset is released.
- d=1 is legal: N = 128/W.
- No combinational path from m_ready to m_valid or out_ready.

Decomposition:
- Shared package msk_drain_pkg:
  - Function computing N.
  - Counter width constant.
  - State encoding localparams IDLE=1'b0, STREAM=1'b1.
- One sub-module, msk_share_word_sel:
  - Purely combinational.
  - Maps buffer plus word index to the W-bit word using the share/word transposition above.
- The FSM, counter, buffer and handshake stay in the top module.

Test Plan:
- Reset then idle, d=2, W=32: hold rst=0 for 3 cycles -> out_ready=0, m_valid=0 during reset. Release -> out_ready=1 the next cycle; busy=0.
- Single capture, no backpressure: share0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a, share1 = 0 (bit-compact interleaved), m_ready=1 -> 8 consecutive words:
  - 0x70b4c55a, 0xd8cdb780, 0x6a7b0430, 0x69c4e0d8, then 4x 0x00000000.
  - m_last only on word 7.
  - out_ready=1 one cycle after the final accept.
- Backpressure: same data, m_ready toggling 1,0,0,1,… -> m_data and m_last stable while stalled. Exactly 8 accepted words, identical to the previous scenario.
- Share ordering: share0 = all-ones, share1 = 128'h0123456789abcdef0011223344556677 -> words:
  - 4x 0xffffffff, then 0x44556677, 0x00112233, 0x89abcdef, 0x01234567.
- Ignored valid and zeroization: pulse cipher_valid during STREAM with different data -> no capture, stream unchanged. After the final word, internal buffer reads 0.
- Reset mid-stream: rst=0 after word 3 accepted -> m_valid=0 immediately after the reset edge. A fresh capture then streams from word 0 with the new data.
